// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its requesters and the shared ALU.
// The arbiter uses the slave modport; the requester/ALU side uses master.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] op_code;
  logic [W*NREQ-1:0] opa;
  logic [W*NREQ-1:0] opb;
  logic [NREQ-1:0]   opa_sign;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    result;
  logic              res_sign;
  logic              err;
  logic              busy;
  logic [3:0]        alu_operator;
  logic [W-1:0]      alu_operand1;
  logic [W-1:0]      alu_operand2;
  logic              alu_op1_sign;
  logic              alu_op2_sign;
  logic [2*W-1:0]    alu_result;
  logic              alu_sign;

  modport slave (
    input  req, op_code, opa, opb, opa_sign, alu_result, alu_sign,
    output grant, done, result, res_sign, err, busy,
           alu_operator, alu_operand1, alu_operand2, alu_op1_sign, alu_op2_sign
  );

  modport master (
    output req, op_code, opa, opb, opa_sign, alu_result, alu_sign,
    input  grant, done, result, res_sign, err, busy,
           alu_operator, alu_operand1, alu_operand2, alu_op1_sign, alu_op2_sign
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between NREQ requesters.
// Validates the latched operation, waits ALU_LAT cycles, then returns the clamped result.
//
// state | meaning
// IDLE  | no owner; arbitrate round-robin from ptr+1
// ISSUE | operands latched to ALU; validate operator/divisor
// WAIT  | count ALU settle cycles, capture result at zero
// RESP  | one-cycle done pulse to the owner
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     owner, owner_n;
  logic [PW-1:0]     winner;
  logic              found;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]   grant, grant_n;
  logic [NREQ-1:0]   done, done_n;
  logic [2*W-1:0]    result, result_n;
  logic              res_sign, res_sign_n;
  logic              err, err_n;
  logic              busy, busy_n;
  logic [3:0]        op, op_n;
  logic [W-1:0]      opnd1, opnd1_n;
  logic [W-1:0]      opnd2, opnd2_n;
  logic              sign1, sign1_n;
  logic              invalid;
  logic              ovf;

  // Scan starts one past the last owner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % NREQ]) begin
        winner = PW'((int'(ptr) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  assign invalid = !(op inside {4'd10, 4'd11, 4'd12, 4'd13}) ||
                   ((op == 4'd13) && (opnd2 == '0));
  assign ovf     = bus.alu_result > (2*W)'(9999);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    cnt_n      = cnt;
    grant_n    = grant;
    done_n     = '0;
    result_n   = result;
    res_sign_n = res_sign;
    err_n      = err;
    op_n       = op;
    opnd1_n    = opnd1;
    opnd2_n    = opnd2;
    sign1_n    = sign1;

    case (state)
      IDLE: begin
        if (found) begin
          state_n         = ISSUE;
          owner_n         = winner;
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          op_n            = bus.op_code[4*int'(winner) +: 4];
          opnd1_n         = bus.opa[W*int'(winner) +: W];
          opnd2_n         = bus.opb[W*int'(winner) +: W];
          sign1_n         = bus.opa_sign[winner];
        end
      end
      ISSUE: begin
        if (invalid) begin
          state_n    = RESP;
          result_n   = '0;
          res_sign_n = 1'b0;
          err_n      = 1'b1;
          done_n     = grant;
        end else begin
          state_n = WAIT;
          cnt_n   = CW'(ALU_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n    = RESP;
          result_n   = ovf ? {{W{1'b0}}, {W{1'b1}}} : bus.alu_result;
          err_n      = ovf;
          res_sign_n = bus.alu_sign;
          done_n     = grant;
        end
      end
      RESP: begin
        state_n = IDLE;
        grant_n = '0;
        ptr_n   = owner;
        op_n    = '0;
        opnd1_n = '0;
        opnd2_n = '0;
        sign1_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      done     <= '0;
      result   <= '0;
      res_sign <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      op       <= '0;
      opnd1    <= '0;
      opnd2    <= '0;
      sign1    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
      grant    <= grant_n;
      done     <= done_n;
      result   <= result_n;
      res_sign <= res_sign_n;
      err      <= err_n;
      busy     <= busy_n;
      op       <= op_n;
      opnd1    <= opnd1_n;
      opnd2    <= opnd2_n;
      sign1    <= sign1_n;
    end
  end

  assign bus.grant        = grant;
  assign bus.done         = done;
  assign bus.result       = result;
  assign bus.res_sign     = res_sign;
  assign bus.err          = err;
  assign bus.busy         = busy;
  assign bus.alu_operator = op;
  assign bus.alu_operand1 = opnd1;
  assign bus.alu_operand2 = opnd2;
  assign bus.alu_op1_sign = sign1;
  assign bus.alu_op2_sign = 1'b0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them when grant rises and done pulses.
module tb_alu_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int ALU_LAT = 1;
  localparam int LAT_OK  = ALU_LAT + 2;
  localparam int LAT_BAD = 2;

  logic clk;
  logic rst;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_arbiter #(.NREQ(NREQ), .W(W), .ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple ALU model; div-by-zero and unknown operators return junk that must be ignored.
  always_comb begin
    bus.alu_result = 32'h0;
    bus.alu_sign   = 1'b0;
    case (bus.alu_operator)
      4'd10: begin
        bus.alu_result = 32'(bus.alu_operand1) + 32'(bus.alu_operand2);
        bus.alu_sign   = bus.alu_op1_sign;
      end
      4'd11: begin
        if (bus.alu_op1_sign) begin
          bus.alu_result = 32'(bus.alu_operand1) + 32'(bus.alu_operand2);
          bus.alu_sign   = 1'b1;
        end else if (bus.alu_operand1 >= bus.alu_operand2) begin
          bus.alu_result = 32'(bus.alu_operand1) - 32'(bus.alu_operand2);
          bus.alu_sign   = 1'b0;
        end else begin
          bus.alu_result = 32'(bus.alu_operand2) - 32'(bus.alu_operand1);
          bus.alu_sign   = 1'b1;
        end
      end
      4'd12: begin
        bus.alu_result = 32'(bus.alu_operand1) * 32'(bus.alu_operand2);
        bus.alu_sign   = bus.alu_op1_sign;
      end
      4'd13: begin
        bus.alu_result = (bus.alu_operand2 != '0) ?
                         32'(bus.alu_operand1) / 32'(bus.alu_operand2) : 32'hDEAD;
        bus.alu_sign   = bus.alu_op1_sign;
      end
      default: begin
        bus.alu_result = 32'h1234;
        bus.alu_sign   = 1'b1;
      end
    endcase
  end

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] res;
    logic        rs;
    logic        e;
    int          lat;
  } vec_t;

  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  int          cyc = 0;
  int          rise_cyc = 0;
  int          exp_lat = 0;
  bit          pend = 1'b0;
  logic [3:0]  prev_grant = '0;
  vec_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("grant_onehot0", 64'($onehot0(bus.grant)), 64'd1);
      chk("done_onehot0", 64'($onehot0(bus.done)), 64'd1);
      if (bus.grant != '0 && prev_grant == '0) begin
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 64'(bus.grant), 64'd0);
        end else begin
          chk("grant_idx", 64'(bus.grant), 64'(1 << exp_q[0].idx));
          chk("alu_operator", 64'(bus.alu_operator), 64'(exp_q[0].op));
          chk("alu_operand1", 64'(bus.alu_operand1), 64'(exp_q[0].a));
          chk("alu_operand2", 64'(bus.alu_operand2), 64'(exp_q[0].b));
          chk("alu_op1_sign", 64'(bus.alu_op1_sign), 64'(exp_q[0].s));
        end
      end
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_idx", 64'(bus.done), 64'(1 << e.idx));
          chk("grant_at_done", 64'(bus.grant), 64'(bus.done));
          chk("result", 64'(bus.result), 64'(e.res));
          chk("res_sign", 64'(bus.res_sign), 64'(e.rs));
          chk("err", 64'(bus.err), 64'(e.e));
          exp_lat = e.lat;
          pend    = 1'b1;
        end
      end
      if (bus.grant == '0 && prev_grant != '0 && pend) begin
        chk("grant_to_done_end_cycles", 64'(cyc - rise_cyc), 64'(exp_lat));
        pend = 1'b0;
      end
    end
    prev_grant = bus.grant;
  end

  // Stimulus helpers
  task automatic set_req(input vec_t v);
    bus.op_code[4*v.idx +: 4] = v.op;
    bus.opa[W*v.idx +: W]     = v.a;
    bus.opb[W*v.idx +: W]     = v.b;
    bus.opa_sign[v.idx]       = v.s;
    bus.req[v.idx]            = 1'b1;
  endtask

  task automatic wait_dones(input int n, input bit drop, output int cycles);
    int seen;
    seen   = 0;
    cycles = 0;
    while (seen < n && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done != '0) begin
        seen++;
        if (drop) bus.req = bus.req & ~bus.done;
      end
    end
    if (seen < n) chk("done_timeout", 64'(seen), 64'(n));
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.req      = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic single(input vec_t v);
    int c;
    exp_q.push_back(v);
    set_req(v);
    @(posedge clk); #1;
    chk("grant_one_cycle", 64'(bus.grant), 64'(1 << v.idx));
    wait_dones(1, 1'b1, c);
    @(posedge clk); #1;
    chk("idle_alu_zero", {bus.alu_operator, bus.alu_operand1, bus.alu_operand2, bus.alu_op1_sign}, 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  function automatic vec_t mk(input int idx, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic s, input logic [31:0] res,
                              input logic rs, input logic e, input int lat);
    vec_t v;
    v.idx = idx; v.op = op; v.a = a; v.b = b; v.s = s;
    v.res = res; v.rs = rs; v.e = e; v.lat = lat;
    return v;
  endfunction

  vec_t singles[10];
  vec_t rr[5];

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst          = 1'b1;
    bus.req      = '0;
    bus.op_code  = '0;
    bus.opa      = '0;
    bus.opb      = '0;
    bus.opa_sign = '0;

    singles[0] = mk(1, 4'd10,   25,  17, 1'b0, 32'd42,       1'b0, 1'b0, LAT_OK);
    singles[1] = mk(2, 4'd13,   50,   0, 1'b0, 32'd0,        1'b0, 1'b1, LAT_BAD);
    singles[2] = mk(3, 4'd12,  200, 100, 1'b1, 32'h0000FFFF, 1'b1, 1'b1, LAT_OK);
    singles[3] = mk(0, 4'd5,     7,   3, 1'b1, 32'd0,        1'b0, 1'b1, LAT_BAD);
    singles[4] = mk(1, 4'd11,   10,  30, 1'b0, 32'd20,       1'b1, 1'b0, LAT_OK);
    singles[5] = mk(2, 4'd13,  100,   7, 1'b0, 32'd14,       1'b0, 1'b0, LAT_OK);
    singles[6] = mk(3, 4'd10, 9990,   9, 1'b0, 32'd9999,     1'b0, 1'b0, LAT_OK);
    singles[7] = mk(0, 4'd10, 9991,   9, 1'b0, 32'h0000FFFF, 1'b0, 1'b1, LAT_OK);
    singles[8] = mk(1, 4'd14,    1,   1, 1'b0, 32'd0,        1'b0, 1'b1, LAT_BAD);
    singles[9] = mk(2, 4'd9,     1,   1, 1'b0, 32'd0,        1'b0, 1'b1, LAT_BAD);

    rr[0] = mk(0, 4'd10, 1, 1, 1'b0, 32'd2,  1'b0, 1'b0, LAT_OK);
    rr[1] = mk(1, 4'd10, 2, 3, 1'b0, 32'd5,  1'b0, 1'b0, LAT_OK);
    rr[2] = mk(2, 4'd12, 3, 4, 1'b0, 32'd12, 1'b0, 1'b0, LAT_OK);
    rr[3] = mk(3, 4'd11, 9, 4, 1'b0, 32'd5,  1'b0, 1'b0, LAT_OK);
    rr[4] = rr[0];

    apply_reset();
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", {bus.res_sign, bus.err, bus.busy}, 64'd0);
    chk("rst_alu", {bus.alu_operator, bus.alu_operand1, bus.alu_operand2,
                    bus.alu_op1_sign, bus.alu_op2_sign}, 64'd0);

    // All four held high from reset release: 0,1,2,3,0 back to back.
    for (int i = 0; i < 5; i++) exp_q.push_back(rr[i]);
    for (int i = 0; i < 4; i++) set_req(rr[i]);
    wait_dones(5, 1'b0, c);
    bus.req = '0;
    chk("rr_cycles", 64'(c), 64'(1 + (ALU_LAT + 1) + 4 * (ALU_LAT + 3)));
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) single(singles[i]);

    // Reset during WAIT aborts silently; requester 0 then wins over 3.
    exp_q.push_back(mk(1, 4'd10, 5, 5, 1'b0, 32'd10, 1'b0, 1'b0, LAT_OK));
    set_req(exp_q[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", 64'(bus.busy), 64'd1);
    rst     = 1'b1;
    bus.req = '0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_grant", 64'(bus.grant), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    exp_q.push_back(mk(0, 4'd10, 3, 4, 1'b0, 32'd7,  1'b0, 1'b0, LAT_OK));
    exp_q.push_back(mk(3, 4'd12, 6, 7, 1'b1, 32'd42, 1'b1, 1'b0, LAT_OK));
    set_req(exp_q[0]);
    set_req(exp_q[1]);
    @(posedge clk); #1;
    chk("post_reset_grant0", 64'(bus.grant), 64'd1);
    wait_dones(2, 1'b1, c);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
